// File: rtl/bit_serial_mult_framer_if.sv
// Operand / serial-link / result bundle between the framer and its neighbours.
// master = producer/consumer/multiplier side, slave = bit_serial_mult_framer.
interface bit_serial_mult_framer_if #(
  parameter int N = 4
);
  logic             op_valid;
  logic             op_ready;
  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;
  logic             x;
  logic             y;
  logic             first_bit;
  logic             last_bit;
  logic             p;
  logic             res_valid;
  logic             res_ready;
  logic [2*N-1:0]   res_product;
  logic             busy;

  modport master (
    output op_valid, op_a, op_b, p, res_ready,
    input  op_ready, x, y, first_bit, last_bit, res_valid, res_product, busy
  );

  modport slave (
    input  op_valid, op_a, op_b, p, res_ready,
    output op_ready, x, y, first_bit, last_bit, res_valid, res_product, busy
  );
endinterface

// File: rtl/bit_serial_mult_framer.sv
// Parallel<->serial framer around a bit-serial multiplier (LSB first, K=2N frame).
// Optional BIT_SERIAL_MULT_FRAMER_SKID_EN adds a one-entry operand holding register.
module bit_serial_mult_framer #(
  parameter int N   = 4,
  parameter int GAP = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  bit_serial_mult_framer_if.slave    bus
);
  localparam int K  = 2 * N;
  localparam int CW = $clog2(K) + 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) + 1 : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [K-1:0]    res_q, res_d;
  logic            x_q, x_d, y_q, y_d;
  logic            first_q, first_d, last_q, last_d;
  logic            op_ready_q, op_ready_d;
  logic            res_valid_q, res_valid_d;
  logic            busy_q;
  logic            accept_s, start_s;
  logic [N-1:0]    src_a_s, src_b_s;
  logic [CW-1:0]   nxt_cnt_s;
`ifdef BIT_SERIAL_MULT_FRAMER_SKID_EN
  logic            hold_vld_q, hold_vld_d;
  logic [N-1:0]    hold_a_q, hold_a_d, hold_b_q, hold_b_d;
`endif

  // Operand bit for frame position idx: sign-extend past the top operand bit.
  function automatic logic sel_bit(input logic [N-1:0] v, input logic [CW-1:0] idx);
    if (idx < CW'(N)) begin
      sel_bit = v[idx[$clog2(N)-1:0]];
    end else begin
      sel_bit = v[N-1];
    end
  endfunction

  assign accept_s  = bus.op_valid & op_ready_q;
  assign nxt_cnt_s = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gcnt_d      = gcnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    x_d         = 1'b0;
    y_d         = 1'b0;
    first_d     = 1'b0;
    last_d      = last_q;
    op_ready_d  = op_ready_q;
    res_valid_d = res_valid_q;
    start_s     = 1'b0;
    src_a_s     = bus.op_a;
    src_b_s     = bus.op_b;
`ifdef BIT_SERIAL_MULT_FRAMER_SKID_EN
    hold_vld_d  = hold_vld_q;
    hold_a_d    = hold_a_q;
    hold_b_d    = hold_b_q;
`endif
    case (state_q)
      ST_IDLE: begin
        last_d = 1'b1;
`ifdef BIT_SERIAL_MULT_FRAMER_SKID_EN
        if (hold_vld_q) begin
          start_s    = 1'b1;
          src_a_s    = hold_a_q;
          src_b_s    = hold_b_q;
          hold_vld_d = 1'b0;
        end else if (accept_s) begin
          start_s = 1'b1;
        end else begin
          start_s = 1'b0;
        end
`else
        op_ready_d = 1'b1;
        if (accept_s) begin
          start_s = 1'b1;
        end else begin
          start_s = 1'b0;
        end
`endif
      end
      ST_SHIFT: begin
        res_d[cnt_q[CW-2:0]] = bus.p;
        if (cnt_q == CW'(K - 1)) begin
          state_d = ST_FLUSH;
          gcnt_d  = GW'(0);
        end else begin
          cnt_d = nxt_cnt_s;
          x_d   = sel_bit(a_q, nxt_cnt_s);
          y_d   = sel_bit(b_q, nxt_cnt_s);
        end
      end
      ST_FLUSH: begin
        if (gcnt_q == GW'(GAP - 1)) begin
          last_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      ST_DONE: begin
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
        end else if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
`ifdef BIT_SERIAL_MULT_FRAMER_SKID_EN
          if (hold_vld_q) begin
            start_s    = 1'b1;
            src_a_s    = hold_a_q;
            src_b_s    = hold_b_q;
            hold_vld_d = 1'b0;
          end else begin
            start_s = 1'b0;
          end
`else
          op_ready_d = 1'b1;
`endif
        end else begin
          res_valid_d = res_valid_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        last_d  = 1'b1;
      end
    endcase
`ifdef BIT_SERIAL_MULT_FRAMER_SKID_EN
    // Pairs offered while a frame is in flight park in the holding register.
    if (accept_s && (state_q != ST_IDLE)) begin
      hold_vld_d = 1'b1;
      hold_a_d   = bus.op_a;
      hold_b_d   = bus.op_b;
    end else begin
      hold_vld_d = hold_vld_d;
    end
    op_ready_d = ~hold_vld_d;
`endif
    if (start_s) begin
      state_d = ST_SHIFT;
      cnt_d   = CW'(0);
      a_d     = src_a_s;
      b_d     = src_b_s;
      x_d     = src_a_s[0];
      y_d     = src_b_s[0];
      first_d = 1'b1;
      last_d  = 1'b0;
`ifndef BIT_SERIAL_MULT_FRAMER_SKID_EN
      op_ready_d = 1'b0;
`endif
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State and registered outputs; reset discards any partial product.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CW'(0);
      gcnt_q      <= GW'(0);
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      x_q         <= 1'b0;
      y_q         <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b1;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BIT_SERIAL_MULT_FRAMER_SKID_EN
      hold_vld_q  <= 1'b0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gcnt_q      <= gcnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      x_q         <= x_d;
      y_q         <= y_d;
      first_q     <= first_d;
      last_q      <= last_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= (state_d != ST_IDLE);
`ifdef BIT_SERIAL_MULT_FRAMER_SKID_EN
      hold_vld_q  <= hold_vld_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
`endif
    end
  end

  assign bus.op_ready    = op_ready_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.first_bit   = first_q;
  assign bus.last_bit    = last_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_product = res_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_bit_serial_mult_framer.sv
// Scoreboard bench: a behavioural serial multiplier drives p, expected products
// (a*b mod 2^K) are queued at accept and checked when res_valid rises.
module tb_bit_serial_mult_framer;
  localparam int N   = 4;
  localparam int GAP = 2;
  localparam int K   = 2 * N;
  localparam int LAT = K + GAP + 1;

  typedef struct {
    logic [K-1:0] prod;
    int           acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   rr_rand = 1'b0;
  exp_t sb[$];

  bit_serial_mult_framer_if #(.N(N)) bus ();

  bit_serial_mult_framer #(.N(N), .GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference multiplier: bit i of the product needs only operand bits 0..i.
  logic [15:0] xa, ya;
  int          idx = K;
  logic        p_s;
  always_comb begin
    int          ci;
    logic [15:0] cx, cy;
    logic [31:0] prod;
    ci = bus.first_bit ? 0 : idx;
    cx = bus.first_bit ? 16'd0 : xa;
    cy = bus.first_bit ? 16'd0 : ya;
    p_s = 1'b0;
    if (ci < K) begin
      prod = 32'((cx | (16'(bus.x) << ci)) * (cy | (16'(bus.y) << ci)));
      p_s  = prod[ci];
    end
  end
  assign bus.p = p_s;

  always @(posedge clk) begin
    if (reset) begin
      idx <= K;
    end else if (bus.first_bit) begin
      xa  <= 16'(bus.x);
      ya  <= 16'(bus.y);
      idx <= 1;
    end else if (idx < K && !bus.last_bit) begin
      xa  <= xa | (16'(bus.x) << idx);
      ya  <= ya | (16'(bus.y) << idx);
      idx <= idx + 1;
    end
  end

  // Record the serial streams of the most recent frame.
  logic xs [K];
  logic ys [K];
  int   scount = K;
  int   fbc = 0;
  always @(negedge clk) begin
    if (bus.last_bit) scount = K;
    if (bus.first_bit && scount == K) begin
      scount = 0;
      fbc = 0;
    end
    if (scount < K && !bus.last_bit) begin
      xs[scount] = bus.x;
      ys[scount] = bus.y;
      scount++;
    end
    if (bus.first_bit) fbc++;
  end

  // Monitor: pop on each new result, then hold it stable while it waits.
  logic         rv_prev = 1'b0;
  logic [K-1:0] cur;
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.res_valid && !rv_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(bus.res_product), 32'hDEAD);
      end else begin
        e = sb.pop_front();
        check("product", 32'(bus.res_product), 32'(e.prod));
        check("latency", 32'(cyc - e.acc_cyc), 32'(LAT));
        cur = e.prod;
      end
    end else if (!reset && bus.res_valid) begin
      check("product_stable", 32'(bus.res_product), 32'(cur));
    end
    rv_prev = bus.res_valid;
  end

  always @(posedge clk) begin
    #1;
    if (rr_rand) bus.res_ready = 1'($urandom_range(0, 1));
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int a, input int b);
    exp_t e;
    int   n;
    bus.op_valid = 1'b1;
    bus.op_a = 4'(a);
    bus.op_b = 4'(b);
    n = 0;
    while (!bus.op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.op_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.op_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      e.prod = K'(a * b);
      e.acc_cyc = cyc;
      sb.push_back(e);
      bus.op_valid = 1'b0;
    end
  endtask

  task automatic wait_res();
    int n = 0;
    while (!bus.res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.res_valid) check("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bus.op_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_op_ready", 32'(bus.op_ready), 32'd0);
    check("reset_last_bit", 32'(bus.last_bit), 32'd1);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_op_ready", 32'(bus.op_ready), 32'd1);
    check("idle_last_bit", 32'(bus.last_bit), 32'd1);
    check("idle_res_valid", 32'(bus.res_valid), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_product", 32'(bus.res_product), 32'd0);
    check("idle_first_x", 32'({bus.first_bit, bus.x, bus.y}), 32'd0);

    // 5 * 7
    send(5, 7);
    wait_res();
    check("p5x7", 32'(bus.res_product), 32'h23);
    check("x_stream_5", 32'({xs[7], xs[6], xs[5], xs[4], xs[3], xs[2], xs[1], xs[0]}), 32'h05);
    check("first_bit_cycles", 32'(fbc), 32'd1);
    @(negedge clk);

    // 1 * -8
    send(1, -8);
    wait_res();
    check("p1xm8", 32'(bus.res_product), 32'hF8);
    check("y_stream_m8", 32'({ys[7], ys[6], ys[5], ys[4], ys[3], ys[2], ys[1], ys[0]}), 32'hF8);
    @(negedge clk);

    // 4 * 4 held in DONE
    bus.res_ready = 1'b0;
    send(4, 4);
    wait_res();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_res_valid", 32'(bus.res_valid), 32'd1);
      check("stall_product", 32'(bus.res_product), 32'h10);
`ifndef BIT_SERIAL_MULT_FRAMER_SKID_EN
      check("stall_op_ready", 32'(bus.op_ready), 32'd0);
`endif
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("after_take_res_valid", 32'(bus.res_valid), 32'd0);

    // reset at SHIFT cnt=3 during 3 * -2
    send(3, -2);
    repeat (3) @(negedge clk);
    check("mid_frame_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_last_bit", 32'(bus.last_bit), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_product", 32'(bus.res_product), 32'd0);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    send(3, -2);
    wait_res();
    check("p3xm2", 32'(bus.res_product), 32'hFA);
    @(negedge clk);

    // exhaustive, back to back, with a randomly stalling consumer
    rr_rand = 1'b1;
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        send(a, b);
      end
    end
    drain();

    // random pairs
    for (int i = 0; i < 40; i++) begin
      send(int'($signed(4'($urandom))), int'($signed(4'($urandom))));
    end
    drain();
    rr_rand = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
